// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith ops plus bit-serial multiply and restoring divide.
// Results are registered and held with a valid/ready handshake until consumed.
module seq_alu #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned SHW  = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero
);

   localparam logic [3:0] OpSrl   = 4'd0;
   localparam logic [3:0] OpSub   = 4'd1;
   localparam logic [3:0] OpSll   = 4'd2;
   localparam logic [3:0] OpOr    = 4'd3;
   localparam logic [3:0] OpSltu  = 4'd4;
   localparam logic [3:0] OpAnd   = 4'd5;
   localparam logic [3:0] OpAdd   = 4'd6;
   localparam logic [3:0] OpXor   = 4'd7;
   localparam logic [3:0] OpLui   = 4'd8;
   localparam logic [3:0] OpSra   = 4'd9;
   localparam logic [3:0] OpSlt   = 4'd10;
   localparam logic [3:0] OpMul   = 4'd11;
   localparam logic [3:0] OpMulhu = 4'd12;
   localparam logic [3:0] OpDivu  = 4'd13;
   localparam logic [3:0] OpRemu  = 4'd14;

   typedef enum logic [1:0] {StIdle, StCalc, StHold} state_e;

   state_e            state_q, state_d;
   logic [3:0]        op_q, op_d;
   logic [XLEN-1:0]   opb_q, opb_d;
   // hi: product high half / partial remainder; lo: product low half / quotient
   logic [XLEN-1:0]   hi_q, hi_d;
   logic [XLEN-1:0]   lo_q, lo_d;
   logic [SHW-1:0]    cnt_q, cnt_d;
   logic [XLEN-1:0]   result_q, result_d;

   logic [SHW-1:0]    shamt;
   logic [XLEN-1:0]   alu_res;
   logic              is_multi;
   logic              is_mul_q;
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_sh;
   logic [XLEN:0]     div_diff;
   logic              div_ge;

   assign shamt    = b[SHW-1:0];
   assign is_multi = (op == OpMul) || (op == OpMulhu) || (op == OpDivu) || (op == OpRemu);
   assign is_mul_q = (op_q == OpMul) || (op_q == OpMulhu);

   assign mul_sum  = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opb_q : {XLEN{1'b0}})};
   assign div_sh   = {hi_q, lo_q[XLEN-1]};
   assign div_diff = div_sh - {1'b0, opb_q};
   // Partial remainder stays below the divisor, so the top bit is a clean borrow flag
   assign div_ge   = ~div_diff[XLEN];

   always_comb begin
      alu_res = '0;
      unique case (op)
         OpSrl:   alu_res = a >> shamt;
         OpSub:   alu_res = a - b;
         OpSll:   alu_res = a << shamt;
         OpOr:    alu_res = a | b;
         OpSltu:  alu_res = {{(XLEN-1){1'b0}}, (a < b)};
         OpAnd:   alu_res = a & b;
         OpAdd:   alu_res = a + b;
         OpXor:   alu_res = a ^ b;
         OpLui:   alu_res = {b[XLEN-13:0], 12'b0};
         OpSra:   alu_res = $unsigned($signed(a) >>> shamt);
         OpSlt:   alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      opb_d     = opb_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      cnt_d     = cnt_q;
      result_d  = result_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;

      unique case (state_q)
         StIdle: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (is_multi) begin
                  state_d = StCalc;
                  op_d    = op;
                  opb_d   = b;
                  hi_d    = '0;
                  lo_d    = a;
                  cnt_d   = '0;
               end else begin
                  state_d  = StHold;
                  result_d = alu_res;
               end
            end
         end
         StCalc: begin
            cnt_d = cnt_q + 1'b1;
            if (is_mul_q) begin
               hi_d = mul_sum[XLEN:1];
               lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
            end else begin
               hi_d = div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
               lo_d = {lo_q[XLEN-2:0], div_ge};
            end
            if (cnt_q == SHW'(XLEN - 1)) begin
               state_d  = StHold;
               cnt_d    = '0;
               result_d = ((op_q == OpMul) || (op_q == OpDivu)) ? lo_d : hi_d;
            end
         end
         StHold: begin
            out_valid = 1'b1;
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         op_q     <= '0;
         opb_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         opb_q    <= opb_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   assign result = result_q;
   assign zero   = (result_q == '0);

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed vectors feed a scoreboard queue; a monitor checks
// latency, result and zero on every output handshake.
module tb_seq_alu;
   localparam int unsigned XLEN = 32;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [3:0]      op = 4'd0;
   logic [XLEN-1:0] a = '0;
   logic [XLEN-1:0] b = '0;
   logic            out_valid;
   logic            out_ready = 1'b1;
   logic [XLEN-1:0] result;
   logic            zero;

   seq_alu #(.XLEN(XLEN)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [XLEN-1:0] res;
      logic            z;
      int              lat;
      int              acc;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      else n_pass++;
   endtask

   // Monitor: latency at the first out_valid cycle, data at the handshake
   initial begin
      bit seen = 1'b0;
      forever begin
         @(negedge clk);
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else begin
               if (!seen) begin
                  check("latency", 64'(cyc - exp_q[0].acc + 1), 64'(exp_q[0].lat));
                  seen = 1'b1;
               end
               if (out_ready) begin
                  check("result", 64'(result), 64'(exp_q[0].res));
                  check("zero", 64'(zero), 64'(exp_q[0].z));
                  void'(exp_q.pop_front());
                  seen = 1'b0;
               end
            end
         end
      end
   end

   // Returns at #1 after the acceptance edge
   task automatic issue(input logic [3:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                        input logic [XLEN-1:0] res, input int lat);
      exp_t e;
      int   t = 0;
      op = o; a = x; b = y; in_valid = 1'b1;
      while (!in_ready && t < 200) begin
         @(posedge clk); #1; t++;
      end
      if (!in_ready) begin
         check("accept_timeout", 64'(in_ready), 64'd1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      e.res = res; e.z = (res == '0); e.lat = lat; e.acc = cyc;
      exp_q.push_back(e);
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 200) begin
         @(posedge clk); t++;
      end
      if (exp_q.size() != 0) begin
         check("drain_timeout", 64'(exp_q.size()), 64'd0);
         exp_q.delete();
      end
      @(posedge clk); #1;
   endtask

   task automatic run(input logic [3:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                      input logic [XLEN-1:0] res, input int lat);
      issue(o, x, y, res, lat);
      drain();
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_result", 64'(result), 64'd0);
      check("rst_zero", 64'(zero), 64'd1);

      run(4'd6,  32'd1,        32'd2,        32'h0000_0003, 1);  // ADD
      run(4'd1,  32'd5,        32'd5,        32'h0000_0000, 1);  // SUB -> zero
      run(4'd9,  32'h8000_0000, 32'h21,      32'hC000_0000, 1);  // SRA, shamt 1
      run(4'd0,  32'h8000_0000, 32'h4,       32'h0800_0000, 1);  // SRL
      run(4'd2,  32'd1,        32'h25,       32'h0000_0020, 1);  // SLL, shamt 5
      run(4'd3,  32'hF0,       32'h0F,       32'h0000_00FF, 1);  // OR
      run(4'd5,  32'hF0,       32'h3C,       32'h0000_0030, 1);  // AND
      run(4'd7,  32'hFF,       32'h0F,       32'h0000_00F0, 1);  // XOR
      run(4'd4,  32'd1,        32'hFFFF_FFFF, 32'd1,        1);  // SLTU
      run(4'd10, 32'd1,        32'hFFFF_FFFF, 32'd0,        1);  // SLT: 1 < -1 false
      run(4'd8,  32'd0,        32'h12345,    32'h1234_5000, 1);  // LUI
      run(4'd1,  32'd0,        32'd1,        32'hFFFF_FFFF, 1);  // SUB wrap
      run(4'd6,  32'hFFFF_FFFF, 32'd1,       32'h0000_0000, 1);  // ADD wrap
      run(4'd15, 32'd5,        32'd6,        32'h0000_0000, 1);  // reserved
      run(4'd11, 32'hFFFF_FFFF, 32'd2,       32'hFFFF_FFFE, 33); // MUL
      run(4'd12, 32'hFFFF_FFFF, 32'd2,       32'h0000_0001, 33); // MULHU
      run(4'd13, 32'd7,        32'd0,        32'hFFFF_FFFF, 33); // DIVU /0
      run(4'd14, 32'd7,        32'd0,        32'h0000_0007, 33); // REMU /0
      run(4'd13, 32'd100,      32'd7,        32'd14,        33); // DIVU
      run(4'd14, 32'd100,      32'd7,        32'd2,         33); // REMU

      // Back-pressure: result held, no new request accepted
      out_ready = 1'b0;
      issue(4'd6, 32'd1, 32'd1, 32'd2, 1);
      for (int i = 0; i < 5; i++) begin
         check("hold_out_valid", 64'(out_valid), 64'd1);
         check("hold_result", 64'(result), 64'd2);
         check("hold_in_ready", 64'(in_ready), 64'd0);
         op = 4'd6; a = 32'd40; b = 32'd2; in_valid = i[0];
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain();
      repeat (3) @(posedge clk);
      #1 check("hold_no_extra_out", 64'(out_valid), 64'd0);

      // Reset mid-divide aborts with no output
      issue(4'd13, 32'd100, 32'd7, 32'd14, 33);
      repeat (9) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      exp_q.delete();
      check("abort_in_ready", 64'(in_ready), 64'd1);
      check("abort_out_valid", 64'(out_valid), 64'd0);
      check("abort_result", 64'(result), 64'd0);
      check("abort_zero", 64'(zero), 64'd1);
      repeat (40) @(posedge clk);
      #1 check("abort_no_out", 64'(out_valid), 64'd0);
      run(4'd6, 32'd3, 32'd4, 32'd7, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

endmodule
